// File: rtl/uart_rx_event_ctrl.sv
// RX event controller: four-phase ack handshake for receiver parity/stop errors and RX interrupt status.
// Optional macro UART_RX_ERR_CNT_EN adds saturating parity/stop error counters (tied to 0 otherwise).
module uart_rx_event_ctrl #(
  parameter int CNT_W = 5,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             p_error,
  input  logic             st_error,
  input  logic [CNT_W-1:0] rx_fifo_cnt,
  input  logic             rx_fifo_rempty,
  input  logic             rx_fifo_rinc,
  input  logic             char_tick,
  input  logic [CNT_W-1:0] rx_thresh,
  input  logic [TO_W-1:0]  to_limit,
  input  logic [2:0]       irq_en,
  input  logic [2:0]       irq_clr,
  output logic             p_error_ack,
  output logic             st_error_ack,
  output logic [2:0]       irq_status,
  output logic             rx_irq,
  output logic [7:0]       p_err_cnt,
  output logic [7:0]       st_err_cnt
);

  typedef enum logic [1:0] {E_IDLE, E_ACK, E_GAP} err_state_e;

  err_state_e       state_q;
  logic             p_meta_q, p_s_q, st_meta_q, st_s_q;
  logic             p_lat_q, st_lat_q, gap_q, p_ack_q, st_ack_q;
  logic             err_start;

  logic [CNT_W-1:0] prev_cnt_q;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             to_clr, to_inc, to_set;
  logic [2:0]       irq_status_q, irq_status_d;
  logic             rx_irq_q, rx_irq_d;

  // The error flags come from the clk26m domain, so each gets a two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      p_meta_q  <= 1'b0;
      p_s_q     <= 1'b0;
      st_meta_q <= 1'b0;
      st_s_q    <= 1'b0;
    end else begin
      // NOTE: nonblocking assignments make every flop sample pre-edge values, which is what forms the chain.
      p_meta_q  <= p_error;
      p_s_q     <= p_meta_q;
      st_meta_q <= st_error;
      st_s_q    <= st_meta_q;
    end
  end

  assign err_start = (state_q == E_IDLE) && (p_s_q || st_s_q);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= E_IDLE;
      p_lat_q  <= 1'b0;
      st_lat_q <= 1'b0;
      gap_q    <= 1'b0;
      p_ack_q  <= 1'b0;
      st_ack_q <= 1'b0;
    end else begin
      case (state_q)
        E_IDLE: if (err_start) begin
          p_lat_q  <= p_s_q;
          st_lat_q <= st_s_q;
          p_ack_q  <= p_s_q;
          st_ack_q <= st_s_q;
          state_q  <= E_ACK;
        end
        // Release only once every flag we acknowledged has been withdrawn by the receiver.
        E_ACK: if (!(p_lat_q && p_s_q) && !(st_lat_q && st_s_q)) begin
          p_ack_q  <= 1'b0;
          st_ack_q <= 1'b0;
          gap_q    <= 1'b0;
          state_q  <= E_GAP;
        end
        E_GAP: begin
          gap_q <= 1'b1;
          if (gap_q) state_q <= E_IDLE;
        end
        default: state_q <= E_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    to_cnt_d = to_cnt_q;
    to_clr   = rx_fifo_rempty || rx_fifo_rinc || (rx_fifo_cnt != prev_cnt_q);
    to_inc   = !to_clr && char_tick && (to_cnt_q != '1);
    if (to_clr) begin
      to_cnt_d = '0;
    end else if (to_inc) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    // Timeout fires on the tick that brings the counter onto the limit, so a later rinc can clear it.
    to_set = to_inc && (to_limit != '0) && (to_cnt_d == to_limit) && !rx_fifo_rempty;

    irq_status_d[0] = (rx_thresh != '0) && (rx_fifo_cnt >= rx_thresh);
    irq_status_d[1] = to_set || (irq_status_q[1] && !(irq_clr[1] || rx_fifo_rinc));
    irq_status_d[2] = err_start || (irq_status_q[2] && !irq_clr[2]);
    rx_irq_d        = |(irq_status_q & irq_en);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev_cnt_q   <= '0;
      to_cnt_q     <= '0;
      irq_status_q <= '0;
      rx_irq_q     <= 1'b0;
    end else begin
      prev_cnt_q   <= rx_fifo_cnt;
      to_cnt_q     <= to_cnt_d;
      irq_status_q <= irq_status_d;
      rx_irq_q     <= rx_irq_d;
    end
  end

  assign p_error_ack  = p_ack_q;
  assign st_error_ack = st_ack_q;
  assign irq_status   = irq_status_q;
  assign rx_irq       = rx_irq_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] p_err_cnt_q, p_err_cnt_d, st_err_cnt_q, st_err_cnt_d;

  always_comb begin
    p_err_cnt_d  = irq_clr[2] ? 8'd0 : p_err_cnt_q;
    st_err_cnt_d = irq_clr[2] ? 8'd0 : st_err_cnt_q;
    // A new error lands on top of a same-cycle clear, so clear plus error leaves a count of 1.
    if (err_start && p_s_q && (p_err_cnt_d != 8'hFF))   p_err_cnt_d  = p_err_cnt_d + 8'd1;
    if (err_start && st_s_q && (st_err_cnt_d != 8'hFF)) st_err_cnt_d = st_err_cnt_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      p_err_cnt_q  <= 8'd0;
      st_err_cnt_q <= 8'd0;
    end else begin
      p_err_cnt_q  <= p_err_cnt_d;
      st_err_cnt_q <= st_err_cnt_d;
    end
  end

  assign p_err_cnt  = p_err_cnt_q;
  assign st_err_cnt = st_err_cnt_q;
`else
  assign p_err_cnt  = 8'd0;
  assign st_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_event_ctrl.sv
// Self-checking bench for uart_rx_event_ctrl: directed handshake/status scenarios plus a
// randomized level/timeout run checked against a behavioural model.
module tb_uart_rx_event_ctrl;

  localparam int CNT_W = 5;
  localparam int TO_W  = 8;
`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_;
  logic             p_error, st_error;
  logic [CNT_W-1:0] rx_fifo_cnt;
  logic             rx_fifo_rempty, rx_fifo_rinc, char_tick;
  logic [CNT_W-1:0] rx_thresh;
  logic [TO_W-1:0]  to_limit;
  logic [2:0]       irq_en, irq_clr;
  logic             p_error_ack, st_error_ack;
  logic [2:0]       irq_status;
  logic             rx_irq;
  logic [7:0]       p_err_cnt, st_err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_p_cnt  = 0;
  int exp_st_cnt = 0;

  uart_rx_event_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk            (clk),
    .rst_           (rst_),
    .p_error        (p_error),
    .st_error       (st_error),
    .rx_fifo_cnt    (rx_fifo_cnt),
    .rx_fifo_rempty (rx_fifo_rempty),
    .rx_fifo_rinc   (rx_fifo_rinc),
    .char_tick      (char_tick),
    .rx_thresh      (rx_thresh),
    .to_limit       (to_limit),
    .irq_en         (irq_en),
    .irq_clr        (irq_clr),
    .p_error_ack    (p_error_ack),
    .st_error_ack   (st_error_ack),
    .irq_status     (irq_status),
    .rx_irq         (rx_irq),
    .p_err_cnt      (p_err_cnt),
    .st_err_cnt     (st_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Outputs are sampled 1 ns after the rising edge; inputs are changed at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int cnt_exp(input int v);
    return CNT_ON ? v : 0;
  endfunction

  task automatic idle_inputs();
    p_error = 1'b0; st_error = 1'b0;
    rx_fifo_cnt = '0; rx_fifo_rempty = 1'b1; rx_fifo_rinc = 1'b0; char_tick = 1'b0;
    rx_thresh = '0; to_limit = '0; irq_en = 3'b000; irq_clr = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ = 1'b0;
    ticks(2);
    total++; if ({p_error_ack, st_error_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {p_error_ack, st_error_ack}); end
    total++; if (irq_status !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", irq_status); end
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", rx_irq); end
    total++; if ({p_err_cnt, st_err_cnt} !== 16'd0) begin bad++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", p_err_cnt, st_err_cnt); end
    rst_ = 1'b1;
    tick();
    total++; if (irq_status !== 3'b000) begin bad++; $display("FAIL post_reset_status: got %b want 000", irq_status); end
    exp_p_cnt = 0; exp_st_cnt = 0;
  endtask

  task automatic test_parity_ack();
    idle_inputs();
    irq_en  = 3'b100;
    p_error = 1'b1;
    ticks(2);
    total++; if (p_error_ack !== 1'b0) begin bad++; $display("FAIL par_ack_early: got %b want 0", p_error_ack); end
    tick();
    exp_p_cnt++;
    total++; if ({p_error_ack, st_error_ack} !== 2'b10) begin bad++; $display("FAIL par_ack_rise: got %b want 10", {p_error_ack, st_error_ack}); end
    total++; if (irq_status !== 3'b100) begin bad++; $display("FAIL par_status: got %b want 100", irq_status); end
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL par_irq_early: got %b want 0", rx_irq); end
    total++; if (p_err_cnt !== 8'(cnt_exp(exp_p_cnt))) begin bad++; $display("FAIL par_cnt: got %0d want %0d", p_err_cnt, cnt_exp(exp_p_cnt)); end
    tick();
    total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL par_irq: got %b want 1", rx_irq); end
    p_error = 1'b0;
    ticks(2);
    total++; if (p_error_ack !== 1'b1) begin bad++; $display("FAIL par_ack_hold: got %b want 1", p_error_ack); end
    tick();
    total++; if (p_error_ack !== 1'b0) begin bad++; $display("FAIL par_ack_fall: got %b want 0", p_error_ack); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (p_error_ack !== 1'b0) begin bad++; $display("FAIL par_gap%0d: got %b want 0", i, p_error_ack); end
    end
    irq_clr = 3'b100;
    tick();
    irq_clr = 3'b000;
    exp_p_cnt = 0; exp_st_cnt = 0;
    total++; if (irq_status !== 3'b000) begin bad++; $display("FAIL par_clr_status: got %b want 000", irq_status); end
    total++; if (p_err_cnt !== 8'd0) begin bad++; $display("FAIL par_clr_cnt: got %0d want 0", p_err_cnt); end
    tick();
    total++; if (rx_irq !== 1'b0) begin bad++; $display("FAIL par_clr_irq: got %b want 0", rx_irq); end
  endtask

  task automatic test_both_errors();
    idle_inputs();
    p_error = 1'b1; st_error = 1'b1;
    ticks(3);
    exp_p_cnt++; exp_st_cnt++;
    total++; if ({p_error_ack, st_error_ack} !== 2'b11) begin bad++; $display("FAIL both_rise: got %b want 11", {p_error_ack, st_error_ack}); end
    total++; if (p_err_cnt !== 8'(cnt_exp(exp_p_cnt))) begin bad++; $display("FAIL both_pcnt: got %0d want %0d", p_err_cnt, cnt_exp(exp_p_cnt)); end
    total++; if (st_err_cnt !== 8'(cnt_exp(exp_st_cnt))) begin bad++; $display("FAIL both_stcnt: got %0d want %0d", st_err_cnt, cnt_exp(exp_st_cnt)); end
    st_error = 1'b0;
    ticks(4);
    total++; if ({p_error_ack, st_error_ack} !== 2'b11) begin bad++; $display("FAIL both_hold: got %b want 11", {p_error_ack, st_error_ack}); end
    p_error = 1'b0;
    ticks(2);
    total++; if ({p_error_ack, st_error_ack} !== 2'b11) begin bad++; $display("FAIL both_hold2: got %b want 11", {p_error_ack, st_error_ack}); end
    tick();
    total++; if ({p_error_ack, st_error_ack} !== 2'b00) begin bad++; $display("FAIL both_fall: got %b want 00", {p_error_ack, st_error_ack}); end
    ticks(3);
    irq_clr = 3'b100;
    tick();
    irq_clr = 3'b000;
    exp_p_cnt = 0; exp_st_cnt = 0;
    total++; if ({irq_status, p_err_cnt, st_err_cnt} !== 19'd0) begin bad++; $display("FAIL both_clr: got status=%b cnt=%0d/%0d want 000 0/0", irq_status, p_err_cnt, st_err_cnt); end
  endtask

  task automatic test_level();
    idle_inputs();
    rx_thresh = 5'd4;
    for (int c = 0; c <= 5; c++) begin
      rx_fifo_cnt = CNT_W'(c); rx_fifo_rempty = (c == 0);
      tick();
      total++; if (irq_status[0] !== (c >= 4)) begin bad++; $display("FAIL level_cnt%0d: got %b want %b", c, irq_status[0], (c >= 4)); end
    end
    irq_clr = 3'b001;
    tick();
    irq_clr = 3'b000;
    total++; if (irq_status[0] !== 1'b1) begin bad++; $display("FAIL level_clr_noeffect: got %b want 1", irq_status[0]); end
    rx_fifo_cnt = 5'd3;
    tick();
    total++; if (irq_status[0] !== 1'b0) begin bad++; $display("FAIL level_drop: got %b want 0", irq_status[0]); end
    rx_thresh = '0;
    for (int c = 0; c <= 16; c += 4) begin
      rx_fifo_cnt = CNT_W'(c); rx_fifo_rempty = (c == 0);
      tick();
      total++; if (irq_status[0] !== 1'b0) begin bad++; $display("FAIL level_off_cnt%0d: got %b want 0", c, irq_status[0]); end
    end
  endtask

  task automatic test_timeout();
    idle_inputs();
    to_limit = 8'd3; irq_en = 3'b010;
    rx_fifo_cnt = 5'd2; rx_fifo_rempty = 1'b0;
    tick();
    total++; if (irq_status !== 3'b000) begin bad++; $display("FAIL to_start: got %b want 000", irq_status); end
    char_tick = 1'b1;
    ticks(2);
    total++; if (irq_status[1] !== 1'b0) begin bad++; $display("FAIL to_tick2: got %b want 0", irq_status[1]); end
    tick();
    char_tick = 1'b0;
    total++; if (irq_status !== 3'b010) begin bad++; $display("FAIL to_tick3: got %b want 010", irq_status); end
    tick();
    total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL to_irq: got %b want 1", rx_irq); end
    rx_fifo_rinc = 1'b1;
    tick();
    rx_fifo_rinc = 1'b0;
    total++; if (irq_status[1] !== 1'b0) begin bad++; $display("FAIL to_rinc_clr: got %b want 0", irq_status[1]); end
    // rinc with a tick: the counter must restart from 0, so two more ticks must not reach 3.
    char_tick = 1'b1; rx_fifo_rinc = 1'b1;
    tick();
    rx_fifo_rinc = 1'b0;
    ticks(2);
    total++; if (irq_status[1] !== 1'b0) begin bad++; $display("FAIL to_rinc_tick: got %b want 0", irq_status[1]); end
    irq_clr = 3'b010;
    tick();
    irq_clr = 3'b000; char_tick = 1'b0;
    total++; if (irq_status[1] !== 1'b1) begin bad++; $display("FAIL to_set_wins: got %b want 1", irq_status[1]); end
    irq_clr = 3'b010;
    tick();
    irq_clr = 3'b000;
    total++; if (irq_status[1] !== 1'b0) begin bad++; $display("FAIL to_clr: got %b want 0", irq_status[1]); end
    idle_inputs();
    ticks(2);
  endtask

  task automatic test_gap_reset();
    idle_inputs();
    irq_en = 3'b100;
    p_error = 1'b1;
    ticks(3);
    exp_p_cnt++;
    total++; if (p_error_ack !== 1'b1) begin bad++; $display("FAIL gap_first_ack: got %b want 1", p_error_ack); end
    p_error = 1'b0;
    ticks(3);
    total++; if (p_error_ack !== 1'b0) begin bad++; $display("FAIL gap_fall: got %b want 0", p_error_ack); end
    p_error = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (p_error_ack !== 1'b0) begin bad++; $display("FAIL gap_hold%0d: got %b want 0", i, p_error_ack); end
    end
    tick();
    exp_p_cnt++;
    total++; if (p_error_ack !== 1'b1) begin bad++; $display("FAIL gap_reentry: got %b want 1", p_error_ack); end
    total++; if (p_err_cnt !== 8'(cnt_exp(exp_p_cnt))) begin bad++; $display("FAIL gap_cnt: got %0d want %0d", p_err_cnt, cnt_exp(exp_p_cnt)); end
    total++; if (rx_irq !== 1'b1) begin bad++; $display("FAIL gap_irq_before_rst: got %b want 1", rx_irq); end
    rst_ = 1'b0;
    #1;
    exp_p_cnt = 0; exp_st_cnt = 0;
    total++; if ({p_error_ack, st_error_ack, irq_status, rx_irq} !== 6'd0) begin bad++; $display("FAIL rst_mid_ack: got ack=%b%b status=%b irq=%b want all 0", p_error_ack, st_error_ack, irq_status, rx_irq); end
    total++; if (p_err_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_cnt: got %0d want 0", p_err_cnt); end
    p_error = 1'b0;
    tick();
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    bit seen;
    idle_inputs();
    for (int n = 0; n < 256; n++) begin
      p_error = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (p_error_ack === 1'b1) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL sat_ack_rise%0d: got no ack want ack within 8 cycles", n); end
      if (exp_p_cnt < 255) exp_p_cnt++;
      p_error = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (p_error_ack === 1'b0) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL sat_ack_fall%0d: got ack stuck want release within 8 cycles", n); end
      ticks(3);
    end
    total++; if (p_err_cnt !== 8'(cnt_exp(exp_p_cnt))) begin bad++; $display("FAIL sat_cnt: got %0d want %0d", p_err_cnt, cnt_exp(exp_p_cnt)); end
    total++; if (st_err_cnt !== 8'd0) begin bad++; $display("FAIL sat_stcnt: got %0d want 0", st_err_cnt); end
    p_error = 1'b1;
    ticks(2);
    irq_clr = 3'b100;
    tick();
    irq_clr = 3'b000;
    exp_p_cnt = 1;
    total++; if (p_err_cnt !== 8'(cnt_exp(exp_p_cnt))) begin bad++; $display("FAIL sat_clr_inc: got %0d want %0d", p_err_cnt, cnt_exp(exp_p_cnt)); end
    total++; if ({p_error_ack, irq_status[2]} !== 2'b11) begin bad++; $display("FAIL sat_clr_set_wins: got ack=%b st2=%b want 1 1", p_error_ack, irq_status[2]); end
    p_error = 1'b0;
    ticks(6);
  endtask

  task automatic test_random();
    int       m_prev, m_since, new_since;
    bit [2:0] m_stat, old_stat;
    bit       m_irq, lvl, act, counted, hit;
    int       hold;
    idle_inputs();
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    tick();
    m_prev = 0; m_since = 0; m_stat = '0; m_irq = 1'b0; hold = 0;
    rx_thresh = CNT_W'($urandom_range(1, 16));
    to_limit  = TO_W'($urandom_range(1, 4));
    irq_en    = 3'b011;
    for (int it = 0; it < 800; it++) begin
      if (hold == 0) begin
        rx_fifo_cnt = CNT_W'($urandom_range(0, 16));
        hold = $urandom_range(1, 8);
      end
      hold--;
      rx_fifo_rempty = (rx_fifo_cnt == '0);
      rx_fifo_rinc   = !rx_fifo_rempty && ($urandom_range(0, 15) == 0);
      char_tick      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) rx_thresh = CNT_W'($urandom_range(0, 16));
      if ($urandom_range(0, 31) == 0) to_limit  = TO_W'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) irq_en    = 3'($urandom_range(0, 7));
      irq_clr = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      tick();
      // Model: count character ticks since the last FIFO activity; the interrupt follows status by one cycle.
      old_stat  = m_stat;
      lvl       = (rx_thresh != 0) && (int'(rx_fifo_cnt) >= int'(rx_thresh));
      act       = rx_fifo_rempty || rx_fifo_rinc || (int'(rx_fifo_cnt) != m_prev);
      counted   = !act && char_tick && (m_since < 255);
      new_since = act ? 0 : (counted ? m_since + 1 : m_since);
      hit       = counted && (to_limit != 0) && (new_since == int'(to_limit)) && !rx_fifo_rempty;
      m_stat[0] = lvl;
      m_stat[1] = hit || (old_stat[1] && !(irq_clr[1] || rx_fifo_rinc));
      m_stat[2] = old_stat[2] && !irq_clr[2];
      m_irq     = |(old_stat & irq_en);
      m_prev    = int'(rx_fifo_cnt);
      m_since   = new_since;
      total++; if (irq_status !== m_stat) begin bad++; $display("FAIL rand_status it=%0d: got %b want %b", it, irq_status, m_stat); end
      total++; if (rx_irq !== m_irq) begin bad++; $display("FAIL rand_irq it=%0d: got %b want %b", it, rx_irq, m_irq); end
    end
    idle_inputs();
    ticks(2);
  endtask

  initial begin
    rst_ = 1'b0;
    idle_inputs();
    test_reset();
    test_parity_ack();
    test_both_errors();
    test_level();
    test_timeout();
    test_gap_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
